alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised sequential ALU: WIDTH-bit datapath, 3-bit opcode, valid/ready in and out, registered result and flags.
//  Adds SUB/XOR/shifts and a multi-cycle shift-add MUL to the ADD/AND/OR set; ADD/AND/OR keep their 2'b00/01/10 codes (zero-extended).
//  Sits between the datapath controller and the register file; one result per cycle for single-cycle ops.
// PARAMETERS
//  WIDTH   8  datapath width in bits (>=2)
//  MUL_EN  1  1: MUL implemented (WIDTH-cycle iterative); 0: op 3'b111 returns 0 with single-cycle latency
// PORTS
//  clk          in   1      clock; all state on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid_i   in   1      operation request valid
//  in_ready_o   out  1      block accepts request this cycle
//  op_i         in   3      opcode (alu_pkg::alu_op_e)
//  a_i          in   WIDTH  operand A
//  b_i          in   WIDTH  operand B (shift amount = b_i[$clog2(WIDTH)-1:0])
//  ci_i         in   1      carry-in (ADD) / borrow-in (SUB)
//  out_valid_o  out  1      result_o/status_o valid
//  out_ready_i  in   1      consumer takes result this cycle
//  result_o     out  WIDTH  registered result
//  status_o     out  4      registered flags {C,Z,N,V}
//  busy_o       out  1      MUL in progress
// BEHAVIOUR
//  Reset: state=IDLE, out_valid_o=0, result_o=0, status_o=0, busy_o=0, MUL counter=0; takes effect immediately, aborts any MUL.
//  Accept: in_valid_i && in_ready_o at a rising edge. in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i).
//  Ops: 000 ADD {C,r}=a+b+ci | 001 AND | 010 OR | 011 SUB r=a-b-ci, C=borrow (1 iff a < b+ci, unsigned)
//       100 XOR | 101 SHL r=a<<sh | 110 SHR r=a>>sh (logical) | 111 MUL r=low WIDTH bits of a*b (unsigned).
//  Flags: Z = (r==0); N = r[WIDTH-1]; V = signed overflow for ADD/SUB, else 0.
//   C: ADD carry-out; SUB borrow; SHL last bit out a[WIDTH-sh]; SHR last bit out a[sh-1]; sh==0 -> C=0;
//   MUL: C = |(high WIDTH bits of product); AND/OR/XOR: C=0.
//  Single-cycle ops: result/status loaded at accept edge; out_valid_o=1 the next cycle (latency 1).
//  FSM: IDLE -(accept MUL, MUL_EN=1)-> MUL -(count==WIDTH-1)-> IDLE; every other accept stays in IDLE.
//   MUL: one shift-add step per cycle, WIDTH steps; result/status loaded on the final step edge.
//   out_valid_o rises WIDTH cycles after the accept edge. busy_o=1 and in_ready_o=0 while in MUL.
//  Output hold: out_valid_o && !out_ready_i -> result_o/status_o stable, in_ready_o=0.
//  Simultaneous drain+accept in one cycle is legal: the new result replaces the old one; full throughput.
//  out_valid_o clears on handshake when no new single-cycle result is loaded that edge.
//  On entry to MUL the output register is empty (guaranteed by in_ready_o); no result is lost.
//  Inputs are sampled only at accept; operand changes during MUL have no effect.
//  Flags are not sticky: each result overwrites all four.
// STRUCTURE
//  alu_pkg: alu_op_e {ADD,AND,OR,SUB,XOR,SHL,SHR,MUL}, state_e {IDLE,MUL}, flag index localparams FLAG_C=3,Z=2,N=1,V=0.
//  Sub-module alu_mul_seq (WIDTH): start/done iterative multiplier, 2*WIDTH accumulator, $clog2(WIDTH)-bit counter.
//  Top level: combinational single-cycle unit, FSM, output register with valid/ready.
// TESTING
//  ADD a=8'hFF b=8'h01 ci=0 -> next cycle r=8'h00, status C=1 Z=1 N=0 V=0.
//  SUB a=8'h80 b=8'h01 ci=0 -> r=8'h7F, V=1 C=0 N=0; SUB a=8'h00 b=8'h01 -> r=8'hFF, C=1 N=1.
//  MUL 8'h0F*8'h11 -> r=8'hFF, C=0, out_valid 8 cycles after accept, in_ready=0 meanwhile.
//   MUL 8'h10*8'h10 -> r=8'h00, C=1 Z=1.
//  Backpressure: out_ready=0 for 5 cycles after ADD -> result stable, in_ready=0; then 4 back-to-back ops, out_ready=1 -> 4 results in 4 cycles.
//  SHL a=8'h81 sh=1 -> r=8'h02, C=1; SHR a=8'h01 sh=1 -> r=8'h00, C=1 Z=1; sh=0 -> r=a, C=0.
//  Reset asserted mid-MUL (cycle 3) -> out_valid=0, busy=0 immediately; after release a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Bit positions inside status {C,Z,N,V}
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per run cycle, WIDTH steps total.
// prod is the accumulator value after the current step, so the caller can capture it on the done edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] addend;

  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
    prod   = acc_q + addend;
    done   = run && (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (run) begin
      acc_q    <= prod;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides, registered result/flags and an optional iterative MUL.
// state | meaning
// IDLE  | accepting requests; single-cycle ops complete at the accept edge
// MUL   | multiplier stepping; input side blocked until the final step loads the result
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       status_o,
  output logic             busy_o
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic               accept;
  logic               mul_start;
  logic               sc_load;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum, diff, shl, shr;
  logic [WIDTH-1:0]   sc_r;
  logic               sc_c, sc_v;
  logic [3:0]         sc_flags;
  logic [WIDTH-1:0]   mul_r;
  logic [3:0]         mul_flags;

  assign in_ready_o = (state_q == IDLE) && (!out_valid_o || out_ready_i);
  assign busy_o     = (state_q == MUL);
  assign accept     = in_valid_i && in_ready_o;
  assign mul_start  = accept && (op_i == OP_MUL) && MUL_EN;
  assign sc_load    = accept && !mul_start;
  assign sh         = b_i[SHW-1:0];

  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, ci_i};
    diff = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, ci_i};
    // Extra bit beside the shifted operand catches the last bit shifted out; sh==0 leaves it 0.
    shl  = {1'b0, a_i} << sh;
    shr  = {a_i, 1'b0} >> sh;
    sc_r = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (op_i)
      OP_ADD: begin
        sc_r = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sc_r = diff[WIDTH-1:0];
        sc_c = diff[WIDTH];
        sc_v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: sc_r = a_i & b_i;
      OP_OR:  sc_r = a_i | b_i;
      OP_XOR: sc_r = a_i ^ b_i;
      OP_SHL: begin
        sc_r = shl[WIDTH-1:0];
        sc_c = shl[WIDTH];
      end
      OP_SHR: begin
        sc_r = shr[WIDTH:1];
        sc_c = shr[0];
      end
      default: sc_r = '0;
    endcase
    sc_flags         = '0;
    sc_flags[FLAG_C] = sc_c;
    sc_flags[FLAG_Z] = (sc_r == '0);
    sc_flags[FLAG_N] = sc_r[WIDTH-1];
    sc_flags[FLAG_V] = sc_v;
  end

  always_comb begin
    mul_r             = mul_prod[WIDTH-1:0];
    mul_flags         = '0;
    mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_Z] = (mul_r == '0);
    mul_flags[FLAG_N] = mul_r[WIDTH-1];
    mul_flags[FLAG_V] = 1'b0;
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .run   (state_q == MUL),
        .a     (a_i),
        .b     (b_i),
        .done  (mul_done),
        .prod  (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The output register is always empty while in MUL, so a MUL completion never competes with a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      status_o    <= '0;
    end else if (sc_load) begin
      out_valid_o <= 1'b1;
      result_o    <= sc_r;
      status_o    <= sc_flags;
    end else if (mul_done) begin
      out_valid_o <= 1'b1;
      result_o    <= mul_r;
      status_o    <= mul_flags;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of single-cycle ops, then MUL, backpressure and reset sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    alu_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] r;
    logic [3:0] s;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  alu_op_e    op = OP_ADD;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       ci = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] status;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;

  vec_t vecs[16];
  vec_t b2b[4];

  alu_seq #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .a_i         (a_in),
    .b_i         (b_in),
    .ci_i        (ci),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .status_o    (status),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input alu_op_e o, input logic [7:0] a, input logic [7:0] b, input logic c);
    in_valid = 1'b1;
    op       = o;
    a_in     = a;
    b_in     = b;
    ci       = c;
  endtask

  task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_r, input logic [3:0] exp_s);
    int cycles;
    int bad;
    cycles = 0;
    bad    = 0;
    @(negedge clk);
    drive(OP_MUL, a, b, 1'b0);
    @(posedge clk);
    #1;
    // Keep a request pending with different operands; it must be neither accepted nor used.
    drive(OP_ADD, 8'hFF, 8'hFF, 1'b1);
    while (!out_valid && cycles < 20) begin
      if (!busy || in_ready) bad++;
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check({name, " latency"}, 32'(cycles), 32'd8);
    check({name, " busy/in_ready during mul"}, 32'(bad), 32'd0);
    check({name, " result"}, 32'(result), 32'(exp_r));
    check({name, " status"}, 32'(status), 32'(exp_s));
    check({name, " busy after"}, 32'(busy), 32'd0);
    check({name, " in_ready after"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check({name, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100};
    vecs[1]  = '{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011};
    vecs[2]  = '{OP_ADD, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000};
    vecs[3]  = '{OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1101};
    vecs[4]  = '{OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000};
    vecs[5]  = '{OP_OR,  8'h00, 8'h00, 1'b0, 8'h00, 4'b0100};
    vecs[6]  = '{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001};
    vecs[7]  = '{OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1010};
    vecs[8]  = '{OP_SUB, 8'h05, 8'h04, 1'b1, 8'h00, 4'b0100};
    vecs[9]  = '{OP_SUB, 8'h7F, 8'hFF, 1'b0, 8'h80, 4'b1011};
    vecs[10] = '{OP_XOR, 8'hAA, 8'hFF, 1'b0, 8'h55, 4'b0000};
    vecs[11] = '{OP_SHL, 8'h81, 8'h01, 1'b0, 8'h02, 4'b1000};
    vecs[12] = '{OP_SHR, 8'h01, 8'h01, 1'b0, 8'h00, 4'b1100};
    vecs[13] = '{OP_SHL, 8'hA5, 8'h08, 1'b0, 8'hA5, 4'b0010};
    vecs[14] = '{OP_SHR, 8'h80, 8'h07, 1'b0, 8'h01, 4'b0000};
    vecs[15] = '{OP_SHL, 8'h01, 8'h07, 1'b0, 8'h80, 4'b0010};

    b2b[0] = '{OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 4'b0000};
    b2b[1] = '{OP_OR,  8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b0010};
    b2b[2] = '{OP_XOR, 8'h0F, 8'h0F, 1'b0, 8'h00, 4'b0100};
    b2b[3] = '{OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0E, 4'b0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset status", 32'(status), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Single-cycle ops, one per cycle with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].r));
      check($sformatf("vec%0d status", i), 32'(status), 32'(vecs[i].s));
    end
    @(posedge clk);
    #1;
    check("table drain", 32'(out_valid), 32'd0);

    // Multi-cycle multiply
    run_mul("mul 0f*11", 8'h0F, 8'h11, 8'hFF, 4'b0010);
    run_mul("mul 10*10", 8'h10, 8'h10, 8'h00, 4'b1100);
    run_mul("mul ff*ff", 8'hFF, 8'hFF, 8'h01, 4'b1000);

    // Backpressure: result must hold while the consumer stalls
    @(negedge clk);
    out_ready = 1'b0;
    drive(OP_ADD, 8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #1;
    drive(OP_XOR, 8'hFF, 8'h00, 1'b0);
    check("bp first valid", 32'(out_valid), 32'd1);
    check("bp first result", 32'(result), 32'h46);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp hold%0d result", k), 32'(result), 32'h46);
      check($sformatf("bp hold%0d status", k), 32'(status), 32'h0);
      check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    // Drain and accept together: four results in four cycles
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(b2b[k].op, b2b[k].a, b2b[k].b, b2b[k].ci);
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d valid", k), 32'(out_valid), 32'd1);
      check($sformatf("b2b%0d result", k), 32'(result), 32'(b2b[k].r));
      check($sformatf("b2b%0d status", k), 32'(status), 32'(b2b[k].s));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply
    @(negedge clk);
    drive(OP_MUL, 8'h0F, 8'h11, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("midmul busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midmul reset busy", 32'(busy), 32'd0);
    check("midmul reset out_valid", 32'(out_valid), 32'd0);
    check("midmul reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(OP_ADD, 8'h03, 8'h04, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post-reset add valid", 32'(out_valid), 32'd1);
    check("post-reset add result", 32'(result), 32'h07);
    check("post-reset add status", 32'(status), 32'h0);
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        if (out_valid || busy) stray++;
      end
      check("no stray mul result", 32'(stray), 32'd0);
    end

    // Reset while a stalled result is held
    @(negedge clk);
    out_ready = 1'b0;
    drive(OP_ADD, 8'h55, 8'hAA, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("held valid", 32'(out_valid), 32'd1);
    check("held status", 32'(status), 32'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("held reset out_valid", 32'(out_valid), 32'd0);
    check("held reset result", 32'(result), 32'd0);
    check("held reset status", 32'(status), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
